// File: rtl/calc1_port_requester.sv
// Host-side initiator for one calc1 request port: accepts an operation, sequences the two-cycle
// request, waits for the response and hands it back. Optional WAIT timeout: CALC1_REQ_TIMEOUT_EN.
module calc1_port_requester #(
    parameter int DATA_W         = 32,
    parameter int CMD_W          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [CMD_W-1:0]  host_cmd,
    input  logic [DATA_W-1:0] host_op1,
    input  logic [DATA_W-1:0] host_op2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_code,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_timeout,
    output logic              busy,
    output logic [CMD_W-1:0]  req_cmd_out,
    output logic [DATA_W-1:0] req_data_out,
    input  logic [1:0]        out_resp,
    input  logic [DATA_W-1:0] out_data
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SEND1 = 3'd1;
    localparam logic [2:0] S_SEND2 = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("calc1_port_requester: TIMEOUT_CYCLES must be >= 2");
    end

    logic [2:0]        r_state;
    logic              r_host_ready;
    logic              r_busy;
    logic              r_rsp_valid;
    logic [1:0]        r_rsp_code;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_timeout;
    logic [CMD_W-1:0]  r_req_cmd;
    logic [DATA_W-1:0] r_req_data;
    logic [DATA_W-1:0] r_op2;
    logic              w_accept;
    logic              w_resp_hit;

    assign w_accept   = host_valid && r_host_ready;
    assign w_resp_hit = (out_resp != 2'b00);

`ifdef CALC1_REQ_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             w_timeout_hit;

    // A response on the final WAIT cycle takes priority over the timeout.
    assign w_timeout_hit = (r_wait_cnt == CNT_LAST) && !w_resp_hit;
`endif

    // Operand 2 is pure data: loaded on accept, consumed in SEND1, never needs clearing.
    always_ff @(posedge c_clk) begin
        if (r_state == S_IDLE && w_accept) begin
            r_op2 <= host_op2;
        end
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_host_ready  <= 1'b1;
            r_busy        <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_code    <= 2'b00;
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b0;
            r_req_cmd     <= '0;
            r_req_data    <= '0;
`ifdef CALC1_REQ_TIMEOUT_EN
            r_wait_cnt    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state      <= S_SEND1;
                        r_host_ready <= 1'b0;
                        r_busy       <= 1'b1;
                        r_req_cmd    <= host_cmd;
                        r_req_data   <= host_op1;
                    end
                end
                S_SEND1: begin
                    r_state    <= S_SEND2;
                    r_req_cmd  <= '0;
                    r_req_data <= r_op2;
                end
                S_SEND2: begin
                    r_state    <= S_WAIT;
                    r_req_data <= '0;
`ifdef CALC1_REQ_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    if (w_resp_hit) begin
                        r_state       <= S_DONE;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_code    <= out_resp;
                        r_rsp_data    <= out_data;
                        r_rsp_timeout <= 1'b0;
`ifdef CALC1_REQ_TIMEOUT_EN
                    end else if (w_timeout_hit) begin
                        r_state       <= S_DONE;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_code    <= 2'b00;
                        r_rsp_data    <= '0;
                        r_rsp_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
`endif
                    end
                end
                S_DONE: begin
                    // host_ready stays low this cycle, so no op can be taken while DONE is left.
                    if (rsp_ready) begin
                        r_state      <= S_IDLE;
                        r_rsp_valid  <= 1'b0;
                        r_host_ready <= 1'b1;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_host_ready <= 1'b1;
                    r_busy       <= 1'b0;
                    r_rsp_valid  <= 1'b0;
                    r_req_cmd    <= '0;
                    r_req_data   <= '0;
                end
            endcase
        end
    end

    assign host_ready   = r_host_ready;
    assign busy         = r_busy;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_code     = r_rsp_code;
    assign rsp_data     = r_rsp_data;
    assign rsp_timeout  = r_rsp_timeout;
    assign req_cmd_out  = r_req_cmd;
    assign req_data_out = r_req_data;

endmodule

// File: tb/tb_calc1_port_requester.sv
// Bench for calc1_port_requester: table vectors, random ops against a calc1 arithmetic model,
// and hand sequences for stray responses, reset mid-op and the WAIT timeout.
module tb_calc1_port_requester;

    logic        c_clk;
    logic        reset;
    logic        host_valid;
    logic        host_ready;
    logic [3:0]  host_cmd;
    logic [31:0] host_op1;
    logic [31:0] host_op2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_code;
    logic [31:0] rsp_data;
    logic        rsp_timeout;
    logic        busy;
    logic [3:0]  req_cmd_out;
    logic [31:0] req_data_out;
    logic [1:0]  out_resp;
    logic [31:0] out_data;

    int n_total = 0;
    int n_bad   = 0;

    calc1_port_requester #(.DATA_W(32), .CMD_W(4), .TIMEOUT_CYCLES(16)) dut (
        .c_clk(c_clk), .reset(reset),
        .host_valid(host_valid), .host_ready(host_ready),
        .host_cmd(host_cmd), .host_op1(host_op1), .host_op2(host_op2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_code(rsp_code), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
        .busy(busy), .req_cmd_out(req_cmd_out), .req_data_out(req_data_out),
        .out_resp(out_resp), .out_data(out_data)
    );

    initial begin
        c_clk = 1'b0;
        forever #5 c_clk = ~c_clk;
    end

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
        int          delay;
        int          stall;
        bit          stray;
        logic [1:0]  exp_code;
        logic [31:0] exp_data;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge c_clk);
        #1;
    endtask

    // calc1 arithmetic: {resp, data}; errors return resp 2 with data 0.
    function automatic logic [33:0] calc_ref(input logic [3:0] cmd, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [32:0] sum;
        case (cmd)
            4'd1: begin
                sum = {1'b0, a} + {1'b0, b};
                calc_ref = sum[32] ? {2'd2, 32'd0} : {2'd1, sum[31:0]};
            end
            4'd2:    calc_ref = (a < b) ? {2'd2, 32'd0} : {2'd1, a - b};
            4'd5:    calc_ref = {2'd1, a << b[4:0]};
            4'd6:    calc_ref = {2'd1, a >> b[4:0]};
            default: calc_ref = {2'd2, 32'd0};
        endcase
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_host_ready"}, 64'(host_ready), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_timeout"}, 64'(rsp_timeout), 64'd0);
        check({tag, "_rsp_code"}, 64'(rsp_code), 64'd0);
        check({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
        check({tag, "_req_cmd"}, 64'(req_cmd_out), 64'd0);
        check({tag, "_req_data"}, 64'(req_data_out), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [3:0] cmd, input logic [31:0] op1,
                          input logic [31:0] op2, input int delay, input int stall,
                          input bit stray, input logic [1:0] exp_code,
                          input logic [31:0] exp_data);
        logic [33:0] resp;
        int          guard;
        time         t_acc;
        resp  = calc_ref(cmd, op1, op2);
        guard = 0;
        while (!host_ready && guard < 20) begin
            step();
            guard++;
        end
        check({tag, "_ready_in_idle"}, 64'(host_ready), 64'd1);
        host_valid = 1'b1;
        host_cmd   = cmd;
        host_op1   = op1;
        host_op2   = op2;
        t_acc      = $time;
        step();
        // SEND1: host inputs scrambled to prove they were captured
        host_valid = 1'($urandom);
        host_cmd   = 4'($urandom);
        host_op1   = $urandom;
        host_op2   = $urandom;
        check({tag, "_s1_cmd"}, 64'(req_cmd_out), 64'(cmd));
        check({tag, "_s1_data"}, 64'(req_data_out), 64'(op1));
        check({tag, "_s1_ready"}, 64'(host_ready), 64'd0);
        check({tag, "_s1_busy"}, 64'(busy), 64'd1);
        step();
        check({tag, "_s2_cmd"}, 64'(req_cmd_out), 64'd0);
        check({tag, "_s2_data"}, 64'(req_data_out), 64'(op2));
        if (stray) begin
            out_resp = 2'd1;
            out_data = 32'hDEAD_BEEF;
        end
        step();
        out_resp = 2'd0;
        for (int k = 0; k < delay; k++) begin
            check({tag, "_wait_valid"}, 64'(rsp_valid), 64'd0);
            check({tag, "_wait_req"}, 64'({req_cmd_out, req_data_out}), 64'd0);
            step();
        end
        out_resp = resp[33:32];
        out_data = resp[31:0];
        step();
        out_resp = 2'd0;
        out_data = $urandom;
        check({tag, "_done_valid"}, 64'(rsp_valid), 64'd1);
        check({tag, "_done_code"}, 64'(rsp_code), 64'(exp_code));
        check({tag, "_done_data"}, 64'(rsp_data), 64'(exp_data));
        check({tag, "_done_timeout"}, 64'(rsp_timeout), 64'd0);
        for (int s = 0; s < stall; s++) begin
            rsp_ready  = 1'b0;
            host_valid = 1'b1;
            out_resp   = 2'($urandom_range(1, 3));
            out_data   = $urandom;
            step();
            check({tag, "_stall_valid"}, 64'(rsp_valid), 64'd1);
            check({tag, "_stall_code"}, 64'(rsp_code), 64'(exp_code));
            check({tag, "_stall_data"}, 64'(rsp_data), 64'(exp_data));
            check({tag, "_stall_ready"}, 64'(host_ready), 64'd0);
        end
        out_resp   = 2'd0;
        rsp_ready  = 1'b1;
        host_valid = 1'b1;
        step();
        rsp_ready = 1'b0;
        check({tag, "_exit_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_exit_ready"}, 64'(host_ready), 64'd1);
        check({tag, "_exit_no_accept"}, 64'(busy), 64'd0);
        if (delay == 0 && stall == 0 && !stray)
            check({tag, "_turnaround"}, 64'(($time - t_acc) / 10), 64'd5);
        host_valid = 1'b0;
    endtask

    vec_t        vecs[8];
    logic [3:0]  rnd_cmds[5];
    logic [33:0] exp_r;
    logic [3:0]  rc;
    logic [31:0] ra;
    logic [31:0] rb;
    int          nwait;

    initial begin
        vecs[0] = '{4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 0, 0, 1'b0, 2'd1, 32'h2000_0000};
        vecs[1] = '{4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 1, 0, 1'b0, 2'd2, 32'h0};
        vecs[2] = '{4'd2, 32'h0000_0001, 32'h0000_000F, 0, 1, 1'b0, 2'd2, 32'h0};
        vecs[3] = '{4'd3, 32'h0000_0001, 32'h0000_0000, 2, 0, 1'b0, 2'd2, 32'h0};
        vecs[4] = '{4'd4, 32'h0000_0001, 32'h0000_0000, 0, 0, 1'b0, 2'd2, 32'h0};
        vecs[5] = '{4'd5, 32'h0000_0003, 32'h0000_0004, 0, 5, 1'b0, 2'd1, 32'h0000_0030};
        vecs[6] = '{4'd6, 32'h8000_0000, 32'h0000_001F, 3, 0, 1'b1, 2'd1, 32'h0000_0001};
        vecs[7] = '{4'd2, 32'h0000_000A, 32'h0000_0003, 0, 0, 1'b0, 2'd1, 32'h0000_0007};
        rnd_cmds = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd3};

        reset      = 1'b1;
        host_valid = 1'b0;
        host_cmd   = '0;
        host_op1   = '0;
        host_op2   = '0;
        rsp_ready  = 1'b0;
        out_resp   = '0;
        out_data   = '0;
        step();
        step();
        check_reset_values("rst");
        reset = 1'b0;
        step();

        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].op1, vecs[i].op2,
                   vecs[i].delay, vecs[i].stall, vecs[i].stray, vecs[i].exp_code,
                   vecs[i].exp_data);

        for (int i = 0; i < 30; i++) begin
            rc    = rnd_cmds[$urandom_range(0, 4)];
            ra    = $urandom;
            rb    = ($urandom_range(0, 1) == 1) ? $urandom : (ra >> 3);
            exp_r = calc_ref(rc, ra, rb);
            run_op($sformatf("rnd%0d", i), rc, ra, rb, $urandom_range(0, 6),
                   $urandom_range(0, 3), 1'($urandom), exp_r[33:32], exp_r[31:0]);
        end

        // Reset while in WAIT, with the calc1 response arriving after the reset.
        host_valid = 1'b1;
        host_cmd   = 4'd1;
        host_op1   = 32'h5;
        host_op2   = 32'h7;
        step();
        host_valid = 1'b0;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_values("midrst");
        step();
        out_resp = 2'd1;
        out_data = 32'hC;
        step();
        out_resp = 2'd0;
        for (int k = 0; k < 6; k++) begin
            check("midrst_no_valid", 64'(rsp_valid), 64'd0);
            check("midrst_idle", 64'(busy), 64'd0);
            step();
        end
        run_op("after_rst", 4'd1, 32'h5, 32'h7, 0, 0, 1'b0, 2'd1, 32'hC);

        // cmd 0 never starts calc1.
        host_valid = 1'b1;
        host_cmd   = 4'd0;
        host_op1   = 32'h0;
        host_op2   = 32'h0;
        step();
        host_valid = 1'b0;
        check("cmd0_s1_cmd", 64'(req_cmd_out), 64'd0);
        step();
        step();
`ifdef CALC1_REQ_TIMEOUT_EN
        nwait = 0;
        while (!rsp_valid && nwait < 100) begin
            nwait++;
            step();
        end
        check("to_wait_cycles", 64'(nwait), 64'd16);
        check("to_valid", 64'(rsp_valid), 64'd1);
        check("to_flag", 64'(rsp_timeout), 64'd1);
        check("to_code", 64'(rsp_code), 64'd0);
        check("to_data", 64'(rsp_data), 64'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("to_exit_ready", 64'(host_ready), 64'd1);
        run_op("resp_last_wait", 4'd1, 32'h10, 32'h20, 15, 0, 1'b0, 2'd1, 32'h30);
        run_op("resp_before_last", 4'd2, 32'h10, 32'h1, 14, 0, 1'b0, 2'd1, 32'hF);
`else
        nwait = 0;
        while (!rsp_valid && nwait < 1000) begin
            nwait++;
            step();
        end
        check("nto_wait_cycles", 64'(nwait), 64'd1000);
        check("nto_busy", 64'(busy), 64'd1);
        check("nto_ready", 64'(host_ready), 64'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_values("nto_rst");
        step();
        run_op("nto_after", 4'd1, 32'h5, 32'h7, 0, 0, 1'b0, 2'd1, 32'hC);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
